// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: ALU control codes and MIPS opcode/funct encodings.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1110;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_SLTIU = 6'b001011;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of MIPS opcode/funct into ALU control code and operands A/B.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int         DATA_W     = ALU_DATA_W,
  parameter logic [3:0] ILLEGAL_OP = 4'b0000
) (
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              illegal
);

  logic [DATA_W-1:0] imm_sx;
  logic [DATA_W-1:0] imm_zx;
  logic [DATA_W-1:0] shamt_zx;

  assign imm_sx   = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zx   = {{(DATA_W-16){1'b0}}, imm};
  assign shamt_zx = {{(DATA_W-5){1'b0}}, shamt};

  always_comb begin
    alu_ctrl = ILLEGAL_OP;
    a        = '0;
    b        = '0;
    illegal  = 1'b0;
    if (opcode == OPC_RTYPE) begin
      case (funct)
        FN_ADD, FN_ADDU: begin alu_ctrl = ALU_ADD; a = rs_data; b = rt_data; end
        FN_SUB, FN_SUBU: begin alu_ctrl = ALU_SUB; a = rs_data; b = rt_data; end
        FN_AND:          begin alu_ctrl = ALU_AND; a = rs_data; b = rt_data; end
        FN_OR:           begin alu_ctrl = ALU_OR;  a = rs_data; b = rt_data; end
        FN_NOR:          begin alu_ctrl = ALU_NOR; a = rs_data; b = rt_data; end
        FN_SLT, FN_SLTU: begin alu_ctrl = ALU_SLT; a = rs_data; b = rt_data; end
        // Shifts operate on rt; the amount travels in B[4:0]
        FN_SLL:          begin alu_ctrl = ALU_SLL; a = rt_data; b = shamt_zx; end
        FN_SRL:          begin alu_ctrl = ALU_SRL; a = rt_data; b = shamt_zx; end
        FN_SRA:          begin alu_ctrl = ALU_SRA; a = rt_data; b = shamt_zx; end
        FN_SLLV:         begin alu_ctrl = ALU_SLL; a = rt_data; b = rs_data;  end
        FN_SRLV:         begin alu_ctrl = ALU_SRL; a = rt_data; b = rs_data;  end
        FN_SRAV:         begin alu_ctrl = ALU_SRA; a = rt_data; b = rs_data;  end
        default:         illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: begin
          alu_ctrl = ALU_ADD; a = rs_data; b = imm_sx;
        end
        OPC_SLTI, OPC_SLTIU: begin alu_ctrl = ALU_SLT; a = rs_data; b = imm_sx; end
        OPC_ANDI:            begin alu_ctrl = ALU_AND; a = rs_data; b = imm_zx; end
        OPC_ORI:             begin alu_ctrl = ALU_OR;  a = rs_data; b = imm_zx; end
        OPC_BEQ, OPC_BNE:    begin alu_ctrl = ALU_SUB; a = rs_data; b = rt_data; end
        // lui is realised as imm << 16
        OPC_LUI:             begin alu_ctrl = ALU_SLL; a = imm_zx; b = DATA_W'(16); end
        default:             illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an instruction and holds it in one ID->EX register slot
// behind a valid/ready handshake with flush.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int         DATA_W     = ALU_DATA_W,
  parameter logic [3:0] ILLEGAL_OP = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [3:0]        ex_alu_ctrl,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic              ex_illegal
);

  logic [3:0]        dec_ctrl;
  logic [DATA_W-1:0] dec_a;
  logic [DATA_W-1:0] dec_b;
  logic              dec_illegal;

  alu_op_decode #(
    .DATA_W     (DATA_W),
    .ILLEGAL_OP (ILLEGAL_OP)
  ) u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .shamt    (shamt),
    .imm      (imm),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .alu_ctrl (dec_ctrl),
    .a        (dec_a),
    .b        (dec_b),
    .illegal  (dec_illegal)
  );

  logic              ex_valid_q,   ex_valid_d;
  logic [3:0]        ex_ctrl_q,    ex_ctrl_d;
  logic [DATA_W-1:0] ex_a_q,       ex_a_d;
  logic [DATA_W-1:0] ex_b_q,       ex_b_d;
  logic              ex_illegal_q, ex_illegal_d;
  logic              accept;

  assign in_ready = !ex_valid_q || ex_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_a_d       = ex_a_q;
    ex_b_d       = ex_b_q;
    ex_illegal_d = ex_illegal_q;
    // Flush wins over accept; data regs are left stale since ex_valid masks them
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d   = 1'b1;
      ex_ctrl_d    = dec_ctrl;
      ex_a_d       = dec_a;
      ex_b_d       = dec_b;
      ex_illegal_d = dec_illegal;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // ID -> EX register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= ILLEGAL_OP;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_illegal_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_alu_ctrl = ex_ctrl_q;
  assign ex_a        = ex_a_q;
  assign ex_b        = ex_b_q;
  assign ex_illegal  = ex_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed literal checks plus randomized traffic compared
// every cycle against a behavioural one-slot model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        ex_illegal;

  alu_issue_stage #(.DATA_W(32), .ILLEGAL_OP(4'b0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .funct       (funct),
    .shamt       (shamt),
    .imm         (imm),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_alu_ctrl (ex_alu_ctrl),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .ex_illegal  (ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } op_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_valid;
  op_t  m_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction-set rules
  function automatic op_t ref_decode(input logic [5:0] opc, input logic [5:0] fn,
                                     input logic [4:0] sh, input logic [15:0] im,
                                     input logic [31:0] rs, input logic [31:0] rt);
    op_t r;
    logic [31:0] sx, zx;
    sx = {{16{im[15]}}, im};
    zx = {16'h0, im};
    r  = '{ctrl: 4'b0000, a: 32'h0, b: 32'h0, ill: 1'b1};
    if (opc == 6'd0) begin
      case (fn)
        6'd32, 6'd33: r = '{4'b0010, rs, rt, 1'b0};
        6'd34, 6'd35: r = '{4'b0110, rs, rt, 1'b0};
        6'd36:        r = '{4'b0000, rs, rt, 1'b0};
        6'd37:        r = '{4'b0001, rs, rt, 1'b0};
        6'd39:        r = '{4'b1100, rs, rt, 1'b0};
        6'd42, 6'd43: r = '{4'b0111, rs, rt, 1'b0};
        6'd0:         r = '{4'b1110, rt, {27'h0, sh}, 1'b0};
        6'd2:         r = '{4'b1010, rt, {27'h0, sh}, 1'b0};
        6'd3:         r = '{4'b1011, rt, {27'h0, sh}, 1'b0};
        6'd4:         r = '{4'b1110, rt, rs, 1'b0};
        6'd6:         r = '{4'b1010, rt, rs, 1'b0};
        6'd7:         r = '{4'b1011, rt, rs, 1'b0};
        default:      ;
      endcase
    end else begin
      case (opc)
        6'd8, 6'd9, 6'd35, 6'd43: r = '{4'b0010, rs, sx, 1'b0};
        6'd10, 6'd11:             r = '{4'b0111, rs, sx, 1'b0};
        6'd12:                    r = '{4'b0000, rs, zx, 1'b0};
        6'd13:                    r = '{4'b0001, rs, zx, 1'b0};
        6'd4, 6'd5:               r = '{4'b0110, rs, rt, 1'b0};
        6'd15:                    r = '{4'b1110, zx, 32'd16, 1'b0};
        default:                  ;
      endcase
    end
    return r;
  endfunction

  task automatic cmp_outputs();
    chk("ex_valid", {31'h0, ex_valid}, {31'h0, m_valid});
    if (m_valid) begin
      chk("ex_alu_ctrl", {28'h0, ex_alu_ctrl}, {28'h0, m_op.ctrl});
      chk("ex_a", ex_a, m_op.a);
      chk("ex_b", ex_b, m_op.b);
      chk("ex_illegal", {31'h0, ex_illegal}, {31'h0, m_op.ill});
    end
  endtask

  // One clock: check in_ready, advance the model on the edge, then compare outputs
  task automatic step();
    logic rdy;
    #1;
    rdy = !m_valid || ex_ready;
    chk("in_ready", {31'h0, in_ready}, {31'h0, rdy});
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (in_valid && rdy) begin
      m_valid = 1'b1;
      m_op    = ref_decode(opcode, funct, shamt, imm, rs_data, rt_data);
    end else if (ex_ready) m_valid = 1'b0;
    #1;
    cmp_outputs();
  endtask

  task automatic set_op(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt);
    opcode = opc; funct = fn; shamt = sh; imm = im; rs_data = rs; rt_data = rt;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'h0, ex_valid}, 32'h0);
    chk({tag, "_ctrl"}, {28'h0, ex_alu_ctrl}, 32'h0);
    chk({tag, "_a"}, ex_a, 32'h0);
    chk({tag, "_b"}, ex_b, 32'h0);
    chk({tag, "_ill"}, {31'h0, ex_illegal}, 32'h0);
  endtask

  logic [5:0] opc_tab [0:12] = '{6'd0, 6'd0, 6'd0, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10,
                                 6'd12, 6'd13, 6'd15, 6'd35, 6'd43};
  logic [5:0] fn_tab  [0:14] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd39, 6'd42,
                                 6'd43, 6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    set_op(6'd0, 6'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    m_valid = 1'b0;
    m_op    = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_held");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset_released");

    // R add
    in_valid = 1'b1;
    set_op(6'd0, 6'b100000, 5'd0, 16'h0, 32'd5, 32'd7);
    step();
    chk("add_valid", {31'h0, ex_valid}, 32'h1);
    chk("add_ctrl", {28'h0, ex_alu_ctrl}, 32'h2);
    chk("add_a", ex_a, 32'd5);
    chk("add_b", ex_b, 32'd7);

    // sra, then addi with negative immediate
    set_op(6'd0, 6'b000011, 5'd4, 16'h0, 32'h1111_2222, 32'h8000_0000);
    step();
    chk("sra_ctrl", {28'h0, ex_alu_ctrl}, 32'hB);
    chk("sra_a", ex_a, 32'h8000_0000);
    chk("sra_b", ex_b, 32'd4);
    set_op(6'b001000, 6'd0, 5'd0, 16'hFFFF, 32'd3, 32'd9);
    step();
    chk("addi_ctrl", {28'h0, ex_alu_ctrl}, 32'h2);
    chk("addi_b", ex_b, 32'hFFFF_FFFF);

    // lui and ori
    set_op(6'b001111, 6'd0, 5'd0, 16'h1234, 32'hDEAD_BEEF, 32'h0);
    step();
    chk("lui_ctrl", {28'h0, ex_alu_ctrl}, 32'hE);
    chk("lui_a", ex_a, 32'h0000_1234);
    chk("lui_b", ex_b, 32'd16);
    set_op(6'b001101, 6'd0, 5'd0, 16'h8000, 32'd1, 32'h0);
    step();
    chk("ori_ctrl", {28'h0, ex_alu_ctrl}, 32'h1);
    chk("ori_b", ex_b, 32'h0000_8000);

    // Stall three cycles with a pending sub, then release
    ex_ready = 1'b0;
    set_op(6'd0, 6'b100010, 5'd0, 16'h0, 32'd9, 32'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
      chk("stall_ctrl", {28'h0, ex_alu_ctrl}, 32'h1);
      chk("stall_b", ex_b, 32'h0000_8000);
    end
    ex_ready = 1'b1;
    step();
    chk("b2b_valid", {31'h0, ex_valid}, 32'h1);
    chk("b2b_ctrl", {28'h0, ex_alu_ctrl}, 32'h6);
    chk("b2b_a", ex_a, 32'd9);
    chk("b2b_b", ex_b, 32'd3);

    // Flush with a valid input
    flush = 1'b1;
    step();
    chk("flush_valid", {31'h0, ex_valid}, 32'h0);
    flush = 1'b0;

    // Undecodable opcode
    set_op(6'b111111, 6'd0, 5'd0, 16'h5555, 32'd1, 32'd2);
    step();
    chk("illegal_valid", {31'h0, ex_valid}, 32'h1);
    chk("illegal_flag", {31'h0, ex_illegal}, 32'h1);
    chk("illegal_ctrl", {28'h0, ex_alu_ctrl}, 32'h0);

    // Asynchronous reset in the middle of a stall
    ex_ready = 1'b0;
    set_op(6'd0, 6'b100100, 5'd0, 16'h0, 32'hF0, 32'h0F);
    step();
    #3 reset = 1'b1;
    #1;
    m_valid = 1'b0;
    m_op    = '0;
    chk_reset_vals("async_reset");
    #2 reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      opcode   = ($urandom_range(0, 9) == 0) ? 6'($urandom) : opc_tab[$urandom_range(0, 12)];
      funct    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 14)];
      shamt    = 5'($urandom);
      imm      = 16'($urandom);
      rs_data  = $urandom;
      rt_data  = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
